// File: rtl/rockets_pool_controller_pkg.sv
// Shared types, constants and helpers for the multi-rocket pool controller.
// Imported by the scan sub-module and the pool top level.
package rockets_pkg;

  typedef logic signed [10:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam coord_t PLAYER_FIRE_SPEED = -11'sd128;

  localparam coord_t SPEEDS [4] = '{
    11'sd32, 11'sd64, 11'sd128, 11'sd256
  };

  // mask bit set = slot busy; result = {found, lowest free index}
  function automatic logic [3:0] first_free(
    input logic [7:0] mask
  );
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!mask[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/rockets_pool_controller_scan.sv
// Alien shooter search: walks the grid bottom-up, column by column,
// from a random start column until a live cell or a full sweep.
module alien_shooter_scan
  import rockets_pkg::*;
#(
  parameter int GRID_COLS = 14,
  parameter int GRID_ROWS = 6
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_start,
  input  logic       i_alive,
  input  logic       i_hold,
  input  logic [3:0] i_rand_col,
  output logic [3:0] o_col,
  output logic [2:0] o_row,
  output logic       o_busy,
  output logic       o_found
);

  localparam int NCELLS = GRID_COLS * GRID_ROWS;
  localparam int VW     = $clog2(NCELLS + 1);
  localparam logic [3:0]    COL_LAST = 4'(GRID_COLS - 1);
  localparam logic [2:0]    ROW_LAST = 3'(GRID_ROWS - 1);
  localparam logic [VW-1:0] VIS_LAST = VW'(NCELLS - 1);

  scan_state_t   r_state, w_state_n;
  logic [3:0]    r_col, w_col_n;
  logic [2:0]    r_row, w_row_n;
  logic [VW-1:0] r_vis, w_vis_n;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_vis   <= '0;
    end else begin
      r_state <= w_state_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_vis   <= w_vis_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_row_n   = r_row;
    w_vis_n   = r_vis;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_n = SCAN;
          w_col_n   = (i_rand_col <= COL_LAST) ? i_rand_col : '0;
          w_row_n   = ROW_LAST;
          w_vis_n   = '0;
        end
      end
      SCAN: begin
        if (i_alive) begin
          // a held shooter keeps its cell until the port frees up
          if (!i_hold) w_state_n = IDLE;
        end else if (r_vis == VIS_LAST) begin
          w_state_n = IDLE;
        end else begin
          w_vis_n = r_vis + 1'b1;
          if (r_row != '0) begin
            w_row_n = r_row - 1'b1;
          end else begin
            w_row_n = ROW_LAST;
            w_col_n = (r_col == COL_LAST) ? '0 : r_col + 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_col   = r_col;
  assign o_row   = r_row;
  assign o_busy  = (r_state == SCAN);
  assign o_found = (r_state == SCAN) && i_alive && !i_hold;

endmodule

// File: rtl/rockets_pool_controller.sv
// Rocket slot pool: allocates player/alien slots, arbitrates the single
// launch port (player first), applies fire cooldown and slot kills.
module rockets_pool_controller
  import rockets_pkg::*;
#(
  parameter int NUM_PLAYER_ROCKETS   = 2,
  parameter int NUM_ALIEN_ROCKETS    = 4,
  parameter int GRID_COLS            = 14,
  parameter int GRID_ROWS            = 6,
  parameter int CELL_SIZE            = 32,
  parameter int PLAYER_MUZZLE_X      = 32,
  parameter int FIRE_COOLDOWN_FRAMES = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic                          player1Fire,
  input  logic                          shootPulse,
  input  logic [1:0]                    randSpeed,
  input  logic [3:0]                    randCol,
  input  logic signed [10:0]            PlayerTLX,
  input  logic signed [10:0]            PlayerTLY,
  input  logic signed [10:0]            aliensTLX,
  input  logic signed [10:0]            aliensTLY,
  input  logic [1:0]                    alien_data,
  input  logic [NUM_PLAYER_ROCKETS-1:0] playerRocketKill,
  input  logic [NUM_ALIEN_ROCKETS-1:0]  alienRocketKill,
  output logic [NUM_PLAYER_ROCKETS-1:0] isActivePlayers,
  output logic [NUM_ALIEN_ROCKETS-1:0]  isActiveAliens,
  output logic                          launchValid,
  output logic                          launchIsAlien,
  output logic [2:0]                    launchSlot,
  output logic signed [10:0]            initialSpeed,
  output logic signed [10:0]            initialX,
  output logic signed [10:0]            initialY,
  output logic [3:0]                    colIdx,
  output logic [2:0]                    rowIdx,
  output logic                          scanBusy
);

  localparam int NP  = NUM_PLAYER_ROCKETS;
  localparam int NA  = NUM_ALIEN_ROCKETS;
  localparam int CDW = (FIRE_COOLDOWN_FRAMES > 0) ?
                       $clog2(FIRE_COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CDW-1:0] COOL_LOAD = CDW'(FIRE_COOLDOWN_FRAMES);
  localparam logic [NP-1:0]  P_ONE = 1;
  localparam logic [NA-1:0]  A_ONE = 1;
  localparam coord_t MUZZLE = 11'(PLAYER_MUZZLE_X);
  localparam coord_t HALF   = 11'(CELL_SIZE / 2);

  logic [CDW-1:0] r_cool;
  logic [7:0]     w_pmask, w_amask;
  logic [3:0]     w_pff, w_aff;
  logic [NP-1:0]  w_pact_n;
  logic [NA-1:0]  w_aact_n;
  logic           w_player_go, w_alien_go, w_scan_start;
  logic [3:0]     w_col;
  logic [2:0]     w_row;
  logic [10:0]    w_col_off, w_row_off;
  coord_t         w_px, w_ax, w_ay;
  logic           w_unused;

  assign w_unused = alien_data[0];

  always_comb begin
    w_pmask = '1;
    w_amask = '1;
    w_pmask[NP-1:0] = isActivePlayers;
    w_amask[NA-1:0] = isActiveAliens;
  end

  assign w_pff = first_free(w_pmask);
  assign w_aff = first_free(w_amask);

  assign w_player_go  = player1Fire && w_pff[3] && (r_cool == '0);
  assign w_scan_start = shootPulse && w_aff[3];

  alien_shooter_scan #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS)
  ) u_scan (
    .clk        (clk),
    .resetN     (resetN),
    .i_start    (w_scan_start),
    .i_alive    (alien_data[1]),
    .i_hold     (w_player_go),
    .i_rand_col (randCol),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_busy     (scanBusy),
    .o_found    (w_alien_go)
  );

  assign colIdx = w_col;
  assign rowIdx = w_row;

  assign w_col_off = 11'(CELL_SIZE) * 11'(w_col);
  assign w_row_off = 11'(CELL_SIZE) * (11'(w_row) + 11'd1);
  assign w_px = PlayerTLX + MUZZLE;
  assign w_ax = aliensTLX + $signed(w_col_off) + HALF;
  assign w_ay = aliensTLY + $signed(w_row_off);

  // launches only pick slots idle now, so kill and set never collide
  always_comb begin
    w_pact_n = isActivePlayers & ~playerRocketKill;
    w_aact_n = isActiveAliens & ~alienRocketKill;
    if (w_player_go) w_pact_n = w_pact_n | (P_ONE << w_pff[2:0]);
    if (w_alien_go)  w_aact_n = w_aact_n | (A_ONE << w_aff[2:0]);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      isActivePlayers <= '0;
      isActiveAliens  <= '0;
      launchValid     <= 1'b0;
      launchIsAlien   <= 1'b0;
      launchSlot      <= '0;
      initialSpeed    <= '0;
      initialX        <= '0;
      initialY        <= '0;
      r_cool          <= '0;
    end else begin
      isActivePlayers <= w_pact_n;
      isActiveAliens  <= w_aact_n;
      launchValid     <= w_player_go | w_alien_go;
      if (w_player_go) begin
        launchIsAlien <= 1'b0;
        launchSlot    <= w_pff[2:0];
        initialSpeed  <= PLAYER_FIRE_SPEED;
        initialX      <= w_px;
        initialY      <= PlayerTLY;
      end else if (w_alien_go) begin
        launchIsAlien <= 1'b1;
        launchSlot    <= w_aff[2:0];
        initialSpeed  <= SPEEDS[randSpeed];
        initialX      <= w_ax;
        initialY      <= w_ay;
      end
      if (w_player_go)
        r_cool <= COOL_LOAD;
      else if (startOfFrame && r_cool != '0)
        r_cool <= r_cool - 1'b1;
    end
  end

endmodule

// File: tb/tb_rockets_pool_controller.sv
// Scoreboard bench for rockets_pool_controller: expected launches and
// scan visits are queued by the stimulus and checked by monitors.
module tb_rockets_pool_controller;

  localparam int NP = 2;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic player1Fire = 1'b0;
  logic shootPulse = 1'b0;
  logic [1:0] randSpeed = '0;
  logic [3:0] randCol = '0;
  logic signed [10:0] PlayerTLX = '0;
  logic signed [10:0] PlayerTLY = '0;
  logic signed [10:0] aliensTLX = '0;
  logic signed [10:0] aliensTLY = '0;
  logic [1:0] alien_data;
  logic [NP-1:0] playerRocketKill = '0;
  logic [NA-1:0] alienRocketKill = '0;
  logic [NP-1:0] isActivePlayers;
  logic [NA-1:0] isActiveAliens;
  logic launchValid, launchIsAlien, scanBusy;
  logic [2:0] launchSlot;
  logic signed [10:0] initialSpeed, initialX, initialY;
  logic [3:0] colIdx;
  logic [2:0] rowIdx;

  bit grid [16][8];

  typedef struct {
    int al; int slot; int spd; int x; int y;
  } lexp_t;

  lexp_t lq[$];
  lexp_t le;
  int vcq[$];
  int vrq[$];
  int vc, vr;
  int total = 0;
  int bad = 0;
  int n;

  always #5 clk = ~clk;

  always_comb alien_data = {grid[colIdx][rowIdx], 1'b0};

  rockets_pool_controller dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .player1Fire      (player1Fire),
    .shootPulse       (shootPulse),
    .randSpeed        (randSpeed),
    .randCol          (randCol),
    .PlayerTLX        (PlayerTLX),
    .PlayerTLY        (PlayerTLY),
    .aliensTLX        (aliensTLX),
    .aliensTLY        (aliensTLY),
    .alien_data       (alien_data),
    .playerRocketKill (playerRocketKill),
    .alienRocketKill  (alienRocketKill),
    .isActivePlayers  (isActivePlayers),
    .isActiveAliens   (isActiveAliens),
    .launchValid      (launchValid),
    .launchIsAlien    (launchIsAlien),
    .launchSlot       (launchSlot),
    .initialSpeed     (initialSpeed),
    .initialX         (initialX),
    .initialY         (initialY),
    .colIdx           (colIdx),
    .rowIdx           (rowIdx),
    .scanBusy         (scanBusy)
  );

  // launch monitor
  always @(negedge clk) begin
    if (resetN && launchValid) begin
      total++;
      if (lq.size() == 0) begin
        bad++;
        $display("FAIL launch_unexpected al=%0d slot=%0d x=%0d y=%0d",
                 launchIsAlien, launchSlot, initialX, initialY);
      end else begin
        le = lq.pop_front();
        if (int'(launchIsAlien) != le.al || int'(launchSlot) != le.slot ||
            int'(initialSpeed) != le.spd || int'(initialX) != le.x ||
            int'(initialY) != le.y) begin
          bad++;
          $display("FAIL launch got al=%0d slot=%0d spd=%0d x=%0d y=%0d exp al=%0d slot=%0d spd=%0d x=%0d y=%0d",
                   launchIsAlien, launchSlot, initialSpeed, initialX,
                   initialY, le.al, le.slot, le.spd, le.x, le.y);
        end
      end
    end
  end

  // scan visit monitor
  always @(negedge clk) begin
    if (resetN && scanBusy && vcq.size() > 0) begin
      vc = vcq.pop_front();
      vr = vrq.pop_front();
      total++;
      if (int'(colIdx) != vc || int'(rowIdx) != vr) begin
        bad++;
        $display("FAIL scan_visit got=(%0d,%0d) exp=(%0d,%0d)",
                 colIdx, rowIdx, vc, vr);
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push_l(input int al, input int slot, input int spd,
                        input int x, input int y);
    lexp_t e;
    e.al = al; e.slot = slot; e.spd = spd; e.x = x; e.y = y;
    lq.push_back(e);
  endtask

  task automatic push_v(input int c, input int r);
    vcq.push_back(c);
    vrq.push_back(r);
  endtask

  task automatic fire();
    player1Fire = 1'b1;
    tick();
    player1Fire = 1'b0;
  endtask

  task automatic sof(input int k);
    repeat (k) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic shoot();
    shootPulse = 1'b1;
    tick();
    shootPulse = 1'b0;
  endtask

  task automatic wait_scan(output int cyc);
    cyc = 0;
    while (scanBusy && cyc < 200) begin
      tick();
      cyc++;
    end
    if (scanBusy) chk("scan_timeout", 1, 0);
  endtask

  task automatic clear_grid();
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < 8; r++)
        grid[c][r] = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, int'({isActivePlayers, isActiveAliens,
        launchValid, launchIsAlien, scanBusy, colIdx, rowIdx,
        launchSlot}), 0);
    chk({nm, "_coords"}, int'(initialSpeed | initialX | initialY), 0);
  endtask

  initial begin
    clear_grid();
    tick(2);
    chk_all_zero("reset");
    resetN = 1'b1;
    tick();

    // first player shot
    PlayerTLX = 11'sd100;
    PlayerTLY = 11'sd400;
    push_l(0, 0, -128, 132, 400);
    fire();
    chk("p_act_first", int'(isActivePlayers), 1);

    // three frames later: cooldown still running
    sof(3);
    fire();
    chk("p_drop_cool", int'(isActivePlayers), 1);

    // cooldown expired
    sof(5);
    PlayerTLX = 11'sd200;
    push_l(0, 1, -128, 232, 400);
    fire();
    chk("p_act_second", int'(isActivePlayers), 3);

    // pool full
    sof(8);
    fire();
    chk("p_drop_full", int'(isActivePlayers), 3);

    // kill player slot 0, kill on an idle alien slot is ignored
    playerRocketKill = 2'b01;
    alienRocketKill = 4'b0100;
    tick();
    playerRocketKill = '0;
    alienRocketKill = '0;
    chk("p_kill0", int'(isActivePlayers), 2);
    chk("a_kill_idle", int'(isActiveAliens), 0);

    // kill slot 1 and launch into slot 0 in the same cycle
    push_l(0, 0, -128, 232, 400);
    playerRocketKill = 2'b10;
    player1Fire = 1'b1;
    tick();
    playerRocketKill = '0;
    player1Fire = 1'b0;
    chk("p_kill_launch", int'(isActivePlayers), 1);

    // alien scan from col 13 down to live cell (0,2)
    clear_grid();
    grid[0][2] = 1'b1;
    aliensTLX = 11'sd10;
    aliensTLY = 11'sd20;
    randSpeed = 2'd2;
    randCol = 4'd13;
    for (int r = 5; r >= 0; r--) push_v(13, r);
    for (int r = 5; r >= 2; r--) push_v(0, r);
    push_l(1, 0, 128, 26, 116);
    shoot();
    wait_scan(n);
    chk("a_scan_len", n, 10);
    chk("a_visits_left", vcq.size(), 0);
    chk("a_act_first", int'(isActiveAliens), 1);

    // player beats the alien on the shared port
    sof(8);
    clear_grid();
    grid[3][5] = 1'b1;
    randCol = 4'd3;
    randSpeed = 2'd3;
    PlayerTLX = 11'sd100;
    push_l(0, 1, -128, 132, 400);
    push_l(1, 1, 256, 122, 212);
    shoot();
    player1Fire = 1'b1;
    tick();
    player1Fire = 1'b0;
    chk("prio_player_first", int'(launchIsAlien), 0);
    tick();
    chk("prio_alien_next", int'(launchIsAlien), 1);
    chk("prio_a_act", int'(isActiveAliens), 3);
    chk("prio_p_act", int'(isActivePlayers), 3);

    // empty grid sweep
    clear_grid();
    randCol = 4'd5;
    shoot();
    wait_scan(n);
    chk("empty_scan_len", n, 84);
    chk("empty_a_act", int'(isActiveAliens), 3);

    // reset in the middle of a sweep
    shoot();
    tick(10);
    chk("mid_busy", int'(scanBusy), 1);
    resetN = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    resetN = 1'b1;
    tick();

    // player X wraps in 11 bits
    PlayerTLX = 11'sd1000;
    PlayerTLY = -11'sd5;
    push_l(0, 0, -128, -1016, -5);
    fire();
    chk("wrap_act", int'(isActivePlayers), 1);

    // out-of-range start column falls back to column 0
    grid[0][5] = 1'b1;
    randCol = 4'd15;
    randSpeed = 2'd0;
    push_v(0, 5);
    push_l(1, 0, 32, 26, 212);
    shoot();
    wait_scan(n);
    chk("oor_scan_len", n, 1);
    chk("oor_a_act", int'(isActiveAliens), 1);

    tick(3);
    chk("launch_queue_drained", lq.size(), 0);
    chk("visit_queue_drained", vcq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rockets_pool_controller.md
Name: rockets_pool_controller

Overview:
- Parametrised multi-rocket successor of the single-rocket controller.
- Manages a pool of NUM_PLAYER_ROCKETS player slots and NUM_ALIEN_ROCKETS alien slots.
- Allocates free slots and arbitrates one shared launch port. Scans the alien grid for a live shooter, enforces a player fire cooldown and clears slots on per-slot kill events.
- Sits between the player/alien matrix blocks and the per-slot single-rocket movers.

Parameters:
- NUM_PLAYER_ROCKETS, 2, player rocket slots (1..8)
- NUM_ALIEN_ROCKETS, 4, alien rocket slots (1..8)
- GRID_COLS, 14, alien grid columns
- GRID_ROWS, 6, alien grid rows
- CELL_SIZE, 32, grid cell pixel size (power of 2)
- PLAYER_MUZZLE_X, 32, X offset of the muzzle from the player TLX
- FIRE_COOLDOWN_FRAMES, 8, frames between accepted player shots (0 = no cooldown)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- player1Fire  in  1  one-cycle fire request
- shootPulse  in  1  one-cycle alien fire request
- randSpeed  in  2  random speed index
- randCol  in  4  random start column
- PlayerTLX, PlayerTLY  in  11 signed  player top-left
- aliensTLX, aliensTLY  in  11 signed  alien grid top-left
- alien_data  in  2  grid cell at colIdx/rowIdx, same cycle; bit1 = alive
- playerRocketKill  in  NUM_PLAYER_ROCKETS  per-slot clear (hit, border, rocket collision)
- alienRocketKill  in  NUM_ALIEN_ROCKETS  per-slot clear
- isActivePlayers  out  NUM_PLAYER_ROCKETS  slot active flags
- isActiveAliens  out  NUM_ALIEN_ROCKETS  slot active flags
- launchValid  out  1  one-cycle launch strobe
- launchIsAlien  out  1  launch targets the alien pool
- launchSlot  out  3  slot index of the launch
- initialSpeed, initialX, initialY  out  11 signed  launch parameters, valid with launchValid
- colIdx  out  4  grid read column
- rowIdx  out  3  grid read row
- scanBusy  out  1  alien scan in progress

Behaviour:
- Reset (resetN low at a clk edge):
  - All outputs, slots, counters and the FSM go to 0/IDLE.
  - Reset mid-scan aborts the scan; an in-flight launch strobe is not emitted.
- All outputs are registered.
- Slot allocation: the lowest-index inactive slot of the relevant pool.
- Player launch:
  - Condition: player1Fire high, a free player slot exists and cooldown == 0.
  - At the next edge: slot set, launchValid=1, launchIsAlien=0, speed=-128, X=PlayerTLX+PLAYER_MUZZLE_X, Y=PlayerTLY.
  - Cooldown loads FIRE_COOLDOWN_FRAMES and decrements on each startOfFrame, saturating at 0.
  - A request with no free slot or nonzero cooldown is dropped, not queued.
- Kill: playerRocketKill[i] / alienRocketKill[i] clear slot i at the next edge.
  - A kill on an inactive slot is ignored.
  - A kill and a launch into different slots in the same cycle both take effect.
  - A launch never targets a slot that is active at decision time.
- Alien scan FSM, states IDLE, SCAN:
  - IDLE -> SCAN on shootPulse when a free alien slot exists; otherwise the pulse is dropped.
  - On entry: colIdx = randCol if randCol < GRID_COLS, else 0; rowIdx = GRID_ROWS-1; visit counter = 0.
  - SCAN, alien_data[1]=1 and no player launch this cycle: launch into the lowest free alien slot.
    - speed = SPEEDS[randSpeed] with SPEEDS = {32,64,128,256}.
    - X = aliensTLX + CELL_SIZE*col + CELL_SIZE/2; Y = aliensTLY + CELL_SIZE*(row+1).
    - Then -> IDLE.
  - SCAN, alive but a player launch is in the same cycle: player has priority; indices are held and the alien retries next cycle.
  - SCAN, not alive: if row > 0, row-1; else row = GRID_ROWS-1 and col+1, wrapping to 0 after GRID_COLS-1. Visit counter +1.
  - Visit counter reaches GRID_COLS*GRID_ROWS with no live cell: -> IDLE with no launch (empty grid).
  - The alien pool cannot fill during SCAN, because only this FSM allocates alien slots.
  - shootPulse during SCAN is ignored.
- Arithmetic: all coordinate sums are 11-bit signed, two's-complement wrap, no saturation.
- Latency:
  - Fire at cycle t -> launch and slot active at t+1.
  - shootPulse at t -> first cell presented at t+1.
  - Alive seen at cycle s -> launch at s+1.

Decomposition:
- Package rockets_pkg holds:
  - SPEEDS table and PLAYER_FIRE_SPEED (-128)
  - scan_state_t enum {IDLE, SCAN}
  - coord_t (logic signed [10:0])
  - function first_free(mask) returning {found, index}
- One sub-module, alien_shooter_scan: FSM, col/row/visit counters and the found/hold handshake.
- Slot registers, cooldown and launch arbitration stay in the top level.

Test Plan:
- Player fire, pools empty, cooldown 0, PlayerTLX=100, PlayerTLY=400 -> next cycle launchValid=1, slot 0, X=132, Y=400, speed=-128, isActivePlayers=01.
- Three fires spaced by 8+ frames with no kills (NUM_PLAYER_ROCKETS=2) -> slots 0, then 1, third dropped. Kill slot 0, fire again after cooldown -> slot 0 reused.
- Fire 3 frames after an accepted fire -> dropped. Fire after 8 startOfFrame pulses -> accepted.
- shootPulse, randCol=13, grid alive only at (col 0, row 2), aliensTLX=10, aliensTLY=20, randSpeed=2 -> visits (13,5..0), then (0,5),(0,4),(0,3),(0,2). Launch X=26, Y=116, speed=128.
- Alien cell found in the same cycle as player1Fire -> player launches first, alien launches the following cycle with unchanged X/Y.
- Empty grid, shootPulse -> exactly 84 scan cycles, no launch, scanBusy drops. Reset asserted mid-scan -> next cycle all outputs 0, FSM in IDLE.
